// File: rtl/ex_pkg.sv
// ex_pkg: operation/result-class encodings and FSM state constants for the execute stage
package ex_pkg;
   localparam logic [7:0] OP_AND  = 8'h24;
   localparam logic [7:0] OP_OR   = 8'h25;
   localparam logic [7:0] OP_XOR  = 8'h26;
   localparam logic [7:0] OP_NOR  = 8'h27;
   localparam logic [7:0] OP_SLL  = 8'h7C;
   localparam logic [7:0] OP_SRL  = 8'h02;
   localparam logic [7:0] OP_SRA  = 8'h03;
   localparam logic [7:0] OP_ROTR = 8'h04;
   localparam logic [7:0] OP_DIV  = 8'h1A;
   localparam logic [7:0] OP_DIVU = 8'h1B;
   localparam logic [2:0] RES_NOP   = 3'b000;
   localparam logic [2:0] RES_LOGIC = 3'b001;
   localparam logic [2:0] RES_SHIFT = 3'b010;
   localparam logic [2:0] RES_DIV   = 3'b110;
   typedef logic [1:0] state_t;
   localparam state_t IDLE     = 2'd0;
   localparam state_t DIV_CALC = 2'd1;
   localparam state_t DIV_DONE = 2'd2;
endpackage

// File: rtl/div_iter.sv
// div_iter: restoring signed/unsigned divider, one quotient bit per cycle
module div_iter
   import ex_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              signed_op,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic              idle,
   output logic              done,
   output logic [DATA_W-1:0] quo,
   output logic [DATA_W-1:0] rem
);
   localparam int CNT_W = $clog2(DATA_W) + 1;
   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] den_q, quo_q, rem_q;
   logic              qneg_q, rneg_q, dz_q, dz;
   logic [DATA_W:0]   trial, diff;
   assign dz    = divisor == '0;
   assign trial = {rem_q, quo_q[DATA_W-1]};
   assign diff  = trial - {1'b0, den_q};
   assign idle  = state == IDLE;
   assign done  = state == DIV_DONE;
   // divide-by-zero keeps the raw dividend and all-ones quotient, no sign fixup
   assign quo   = dz_q ? quo_q : (qneg_q ? -quo_q : quo_q);
   assign rem   = dz_q ? rem_q : (rneg_q ? -rem_q : rem_q);
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         den_q  <= '0;
         quo_q  <= '0;
         rem_q  <= '0;
         qneg_q <= 1'b0;
         rneg_q <= 1'b0;
         dz_q   <= 1'b0;
      end else if (abort) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: if (start) begin
               dz_q   <= dz;
               qneg_q <= signed_op & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
               rneg_q <= signed_op & dividend[DATA_W-1];
               den_q  <= signed_op & divisor[DATA_W-1] ? -divisor : divisor;
               quo_q  <= dz ? '1 : (signed_op & dividend[DATA_W-1] ? -dividend : dividend);
               rem_q  <= dz ? dividend : '0;
               cnt    <= CNT_W'(DATA_W);
               state  <= dz ? DIV_DONE : DIV_CALC;
            end
            DIV_CALC: begin
               rem_q <= diff[DATA_W] ? trial[DATA_W-1:0] : diff[DATA_W-1:0];
               quo_q <= {quo_q[DATA_W-2:0], ~diff[DATA_W]};
               cnt   <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) state <= DIV_DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: rtl/ex_iter.sv
// ex_iter: execute stage with single-cycle logic/shift ALU and iterative divider
module ex_iter
   import ex_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int SHAMT_W   = $clog2(DATA_W),
   parameter int REGADDR_W = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic [7:0]           aluop_i,
   input  logic [2:0]           alusel_i,
   input  logic [DATA_W-1:0]    reg1_i,
   input  logic [DATA_W-1:0]    reg2_i,
   input  logic [REGADDR_W-1:0] wd_i,
   input  logic                 wreg_i,
   output logic                 valid_o,
   output logic [REGADDR_W-1:0] wd_o,
   output logic                 wreg_o,
   output logic [DATA_W-1:0]    wdata_o,
   output logic                 whilo_o,
   output logic [DATA_W-1:0]    hi_o,
   output logic [DATA_W-1:0]    lo_o
);
   logic                 accept, is_div, start, done, ok;
   logic [DATA_W-1:0]    res, quo, rem;
   logic [2*DATA_W-1:0]  rot;
   logic [SHAMT_W-1:0]   sh;
   logic [REGADDR_W-1:0] div_wd;
   assign sh     = reg1_i[SHAMT_W-1:0];
   assign rot    = {reg2_i, reg2_i} >> sh;
   assign is_div = alusel_i == RES_DIV && (aluop_i == OP_DIV || aluop_i == OP_DIVU);
   assign accept = valid_i & ready_o & ~flush_i;
   assign start  = accept & is_div;
   always_comb begin
      res = '0;
      ok  = 1'b1;
      case ({alusel_i, aluop_i})
         {RES_LOGIC, OP_AND}:  res = reg1_i & reg2_i;
         {RES_LOGIC, OP_OR}:   res = reg1_i | reg2_i;
         {RES_LOGIC, OP_XOR}:  res = reg1_i ^ reg2_i;
         {RES_LOGIC, OP_NOR}:  res = ~(reg1_i | reg2_i);
         {RES_SHIFT, OP_SLL}:  res = reg2_i << sh;
         {RES_SHIFT, OP_SRL}:  res = reg2_i >> sh;
         {RES_SHIFT, OP_SRA}:  res = $signed(reg2_i) >>> sh;
         {RES_SHIFT, OP_ROTR}: res = rot[DATA_W-1:0];
         default:              ok  = 1'b0;
      endcase
   end
   div_iter #(.DATA_W(DATA_W)) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (flush_i),
      .signed_op (aluop_i == OP_DIV),
      .dividend  (reg1_i),
      .divisor   (reg2_i),
      .idle      (ready_o),
      .done      (done),
      .quo       (quo),
      .rem       (rem)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_o <= 1'b0;
         wd_o    <= '0;
         wreg_o  <= 1'b0;
         wdata_o <= '0;
         whilo_o <= 1'b0;
         hi_o    <= '0;
         lo_o    <= '0;
         div_wd  <= '0;
      end else begin
         valid_o <= 1'b0;
         whilo_o <= 1'b0;
         if (start) div_wd <= wd_i;
         // flush wins over a divide that would complete this edge
         if (done && !flush_i) begin
            valid_o <= 1'b1;
            whilo_o <= 1'b1;
            wreg_o  <= 1'b0;
            wd_o    <= div_wd;
            hi_o    <= rem;
            lo_o    <= quo;
         end else if (accept && !is_div) begin
            valid_o <= 1'b1;
            wd_o    <= wd_i;
            wreg_o  <= wreg_i & ok;
            wdata_o <= res;
         end
      end
   end
endmodule

// File: tb/tb_ex_iter.sv
// tb_ex_iter: directed vectors with queued expectations checked by a valid_o monitor
module tb_ex_iter;
   import ex_pkg::*;
   typedef struct {
      int          cyc;
      logic        div;
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;
   logic        clk = 1'b0, rst = 1'b1, flush_i = 1'b0, valid_i = 1'b0, wreg_i = 1'b0;
   logic [7:0]  aluop_i = '0;
   logic [2:0]  alusel_i = '0;
   logic [31:0] reg1_i = '0, reg2_i = '0;
   logic [4:0]  wd_i = '0;
   logic        ready_o, valid_o, wreg_o, whilo_o;
   logic [4:0]  wd_o;
   logic [31:0] wdata_o, hi_o, lo_o;
   int          checks = 0, fails = 0, cyc = 0;
   exp_t        sb[$];
   exp_t        e;
   ex_iter dut (
      .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
      .aluop_i(aluop_i), .alusel_i(alusel_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
      .wd_i(wd_i), .wreg_i(wreg_i), .valid_o(valid_o), .wd_o(wd_o), .wreg_o(wreg_o),
      .wdata_o(wdata_o), .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", n, act, exp, cyc);
      end
   endfunction
   always @(negedge clk) begin
      if (!rst && valid_o) begin
         if (sb.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
         else begin
            e = sb.pop_front();
            chk("latency_cycle", cyc, e.cyc);
            chk("wd_o", {27'd0, wd_o}, {27'd0, e.wd});
            chk("whilo_o", {31'd0, whilo_o}, {31'd0, e.div});
            chk("wreg_o", {31'd0, wreg_o}, {31'd0, e.wreg});
            if (e.div) begin
               chk("hi_o", hi_o, e.hi);
               chk("lo_o", lo_o, e.lo);
            end else chk("wdata_o", wdata_o, e.wdata);
         end
      end else if (!rst) chk("whilo_without_valid", {31'd0, whilo_o}, 32'd0);
   end
   task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a, b,
                        input logic [4:0] w, input logic we);
      valid_i = 1'b1; aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b; wd_i = w; wreg_i = we;
   endtask
   task automatic alu(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a, b,
                      input logic [4:0] w, input logic we, input logic ewreg, input logic [31:0] wdata);
      drive(op, sel, a, b, w, we);
      sb.push_back('{cyc + 1, 1'b0, w, ewreg, wdata, 32'd0, 32'd0});
      @(posedge clk); #1;
      valid_i = 1'b0;
   endtask
   task automatic div(input logic [7:0] op, input logic [31:0] a, b, input logic [4:0] w,
                      input int lat, input logic push, input logic [31:0] hi, lo);
      drive(op, RES_DIV, a, b, w, 1'b1);
      if (push) sb.push_back('{cyc + lat, 1'b1, w, 1'b0, 32'd0, hi, lo});
      @(posedge clk); #1;
      valid_i = 1'b0;
      if (push) begin
         for (int i = 1; i < lat; i++) begin
            chk("ready_low_during_div", {31'd0, ready_o}, 32'd0);
            @(posedge clk); #1;
         end
         chk("ready_high_after_div", {31'd0, ready_o}, 32'd1);
      end
   endtask
   task automatic chk_cleared(input string n);
      chk({n, "_ready"}, {31'd0, ready_o}, 32'd1);
      chk({n, "_outputs"}, {valid_o, wreg_o, whilo_o, wd_o, 24'd0}, 32'd0);
      chk({n, "_data"}, wdata_o | hi_o | lo_o, 32'd0);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog_timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end
   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_cleared("reset");
      rst = 1'b0;
      @(posedge clk); #1;
      alu(OP_SRA, RES_SHIFT, 32'd4, 32'h8000_0010, 5'd3, 1'b1, 1'b1, 32'hF800_0001);
      alu(OP_ROTR, RES_SHIFT, 32'd8, 32'h1234_5678, 5'd4, 1'b0, 1'b0, 32'h7812_3456);
      alu(OP_OR, RES_LOGIC, 32'hF0F0_0000, 32'h0000_0F0F, 5'd5, 1'b1, 1'b1, 32'hF0F0_0F0F);
      alu(OP_NOR, RES_LOGIC, 32'd0, 32'd0, 5'd6, 1'b1, 1'b1, 32'hFFFF_FFFF);
      alu(OP_SLL, RES_SHIFT, 32'd0, 32'hA5A5_A5A5, 5'd7, 1'b1, 1'b1, 32'hA5A5_A5A5);
      alu(OP_SRL, RES_SHIFT, 32'd31, 32'h8000_0000, 5'd8, 1'b1, 1'b1, 32'h0000_0001);
      alu(OP_XOR, RES_LOGIC, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd9, 1'b1, 1'b1, 32'hF00F_F00F);
      alu(OP_AND, RES_LOGIC, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd10, 1'b1, 1'b1, 32'h0F00_0F00);
      alu(OP_SLL, RES_LOGIC, 32'd1, 32'h1, 5'd11, 1'b1, 1'b0, 32'd0);
      alu(8'h55, RES_SHIFT, 32'd1, 32'h1, 5'd12, 1'b1, 1'b0, 32'd0);
      div(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd13, 34, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      div(OP_DIVU, 32'd100, 32'd7, 5'd14, 34, 1'b1, 32'd2, 32'd14);
      div(OP_DIVU, 32'h1234, 32'd0, 5'd15, 2, 1'b1, 32'h1234, 32'hFFFF_FFFF);
      div(OP_DIV, 32'hFFFF_FFFB, 32'd0, 5'd16, 2, 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
      div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 34, 1'b1, 32'd0, 32'h8000_0000);
      div(OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd18, 34, 1'b1, 32'd1, 32'hFFFF_FFFD);
      alu(OP_OR, RES_LOGIC, 32'h1, 32'h2, 5'd19, 1'b1, 1'b1, 32'h3);
      div(OP_DIV, 32'd100, 32'd7, 5'd20, 0, 1'b0, 32'd0, 32'd0);
      repeat (9) @(posedge clk);
      #1;
      drive(OP_OR, RES_LOGIC, 32'h10, 32'h01, 5'd21, 1'b1);
      flush_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      flush_i = 1'b0;
      chk("ready_after_flush", {31'd0, ready_o}, 32'd1);
      alu(OP_OR, RES_LOGIC, 32'h40, 32'h04, 5'd22, 1'b1, 1'b1, 32'h44);
      repeat (40) @(posedge clk);
      #1;
      div(OP_DIVU, 32'd50, 32'd3, 5'd23, 0, 1'b0, 32'd0, 32'd0);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk_cleared("mid_div_reset");
      rst = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      alu(OP_XOR, RES_LOGIC, 32'hF, 32'h3, 5'd24, 1'b1, 1'b1, 32'hC);
      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
